// File: rtl/matrix_hex_scroller_if.sv
// Bundle of control, data and display signals between the coprocessor and matrix_hex_scroller.
// The master modport drives the controls and data; the slave modport is the scroller itself.
interface matrix_hex_scroller_if #(
    parameter int unsigned N      = 3,
    parameter int unsigned EW     = 19,
    parameter int unsigned DW     = 25,
    parameter int unsigned DIGITS = 6
);
    localparam int unsigned IDX_W = (N * N > 1) ? $clog2(N * N) : 1;

    logic                  load;
    logic                  next;
    logic                  clear;
    logic                  auto_en;
    logic                  sel_det;
    logic [N*N*EW-1:0]     matriz;
    logic [DW-1:0]         det;
    logic [DIGITS*7-1:0]   hex_seg;
    logic [IDX_W-1:0]      elem_idx;
    logic                  valid;

    modport master (
        output load, next, clear, auto_en, sel_det, matriz, det,
        input  hex_seg, elem_idx, valid
    );

    modport slave (
        input  load, next, clear, auto_en, sel_det, matriz, det,
        output hex_seg, elem_idx, valid
    );
endinterface

// File: rtl/matrix_hex_scroller.sv
// Snapshots a result matrix or determinant and scrolls it onto a seven-segment HEX bank.
// Define SIGNED_DISP_EN for sign-magnitude display (minus sign on the top digit).
module matrix_hex_scroller #(
    parameter int unsigned N      = 3,
    parameter int unsigned EW     = 19,
    parameter int unsigned DW     = 25,
    parameter int unsigned DIGITS = 6,
    parameter int unsigned TICKS  = 25000000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    matrix_hex_scroller_if.slave bus
);
    localparam int unsigned NN     = N * N;
    localparam int unsigned IDX_W  = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned DISP_W = DIGITS * 4;
    localparam int unsigned TW     = (TICKS > 1) ? $clog2(TICKS) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StScroll = 2'd1,
        StDet    = 2'd2
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [IDX_W-1:0]    r_elem_idx;
    logic [IDX_W-1:0]    w_idx_d;
    logic [TW-1:0]       r_timer;
    logic [TW-1:0]       w_timer_d;
    logic [NN*EW-1:0]    r_mat;
    logic [DW-1:0]       r_det;
    logic [DIGITS*7-1:0] r_hex_seg;
    logic                r_valid;

    logic                w_expire;
    logic                w_adv;
    logic [EW-1:0]       w_elems [NN];
    logic [EW-1:0]       w_elem;
    logic [DISP_W-1:0]   w_elem_ext;
    logic [DISP_W-1:0]   w_det_ext;
    logic [DISP_W-1:0]   w_disp;
    logic [DIGITS*7-1:0] w_seg;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // FSM: state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM: next state, with load taking priority over clear
    always_comb begin
        w_state_d = r_state;
        if (bus.load) begin
            w_state_d = bus.sel_det ? StDet : StScroll;
        end else if (bus.clear) begin
            w_state_d = StIdle;
        end
    end

    assign w_expire = bus.auto_en && (r_timer == TW'(TICKS - 1));
    // A next pulse coinciding with timer expiry still yields a single step.
    assign w_adv    = (r_state == StScroll) && (bus.next || w_expire);

    always_comb begin
        w_idx_d   = r_elem_idx;
        w_timer_d = r_timer;
        if (bus.load) begin
            w_idx_d   = '0;
            w_timer_d = '0;
        end else if (bus.clear) begin
            w_timer_d = '0;
        end else begin
            if (w_adv) begin
                w_idx_d = (r_elem_idx == IDX_W'(NN - 1)) ? '0 : r_elem_idx + 1'b1;
            end
            if (w_adv || !bus.auto_en || (r_state != StScroll)) begin
                w_timer_d = '0;
            end else begin
                w_timer_d = r_timer + 1'b1;
            end
        end
    end

    // Element 0 sits in the MSBs of the flattened snapshot.
    for (genvar g = 0; g < NN; g++) begin : g_unpack
        assign w_elems[g] = r_mat[(NN-1-g)*EW +: EW];
    end

    assign w_elem = w_elems[r_elem_idx];

    if (EW >= DISP_W) begin : g_elem_trunc
        logic w_unused_elem;
        assign w_elem_ext    = w_elem[DISP_W-1:0];
        assign w_unused_elem = ^w_elem;
    end else begin : g_elem_sext
        assign w_elem_ext = {{(DISP_W-EW){w_elem[EW-1]}}, w_elem};
    end

    if (DW >= DISP_W) begin : g_det_trunc
        logic w_unused_det;
        assign w_det_ext    = r_det[DISP_W-1:0];
        assign w_unused_det = ^r_det;
    end else begin : g_det_sext
        assign w_det_ext = {{(DISP_W-DW){r_det[DW-1]}}, r_det};
    end

    assign w_disp = (r_state == StDet) ? w_det_ext : w_elem_ext;

`ifdef SIGNED_DISP_EN
    localparam int unsigned MAG_W = (DIGITS - 1) * 4;

    logic             w_neg;
    logic [MAG_W-1:0] w_mag;
    logic             w_unused_mid;

    // Low bits of the negation depend only on low bits, so negate the truncated field.
    assign w_neg        = w_disp[DISP_W-1];
    assign w_mag        = w_neg ? (~w_disp[MAG_W-1:0] + 1'b1) : w_disp[MAG_W-1:0];
    assign w_unused_mid = ^w_disp;

    always_comb begin
        w_seg = '1;
        for (int k = 0; k < DIGITS - 1; k++) begin
            w_seg[7*k +: 7] = seg7(w_mag[4*k +: 4]);
        end
        w_seg[7*(DIGITS-1) +: 7] = w_neg ? 7'b0111111 : 7'b1111111;
    end
`else
    always_comb begin
        w_seg = '1;
        for (int k = 0; k < DIGITS; k++) begin
            w_seg[7*k +: 7] = seg7(w_disp[4*k +: 4]);
        end
    end
`endif

    // Display lags the state/index by one cycle; valid is registered alongside it.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_elem_idx <= '0;
            r_timer    <= '0;
            r_mat      <= '0;
            r_det      <= '0;
            r_hex_seg  <= '1;
            r_valid    <= 1'b0;
        end else begin
            r_elem_idx <= w_idx_d;
            r_timer    <= w_timer_d;
            if (bus.load) begin
                r_mat <= bus.matriz;
                r_det <= bus.det;
            end
            r_hex_seg <= (r_state == StIdle) ? '1 : w_seg;
            r_valid   <= (r_state != StIdle);
        end
    end

    assign bus.hex_seg  = r_hex_seg;
    assign bus.elem_idx = r_elem_idx;
    assign bus.valid    = r_valid;
endmodule

// File: tb/tb_matrix_hex_scroller.sv
// Directed self-checking bench for matrix_hex_scroller (TICKS shortened to 4).
module tb_matrix_hex_scroller;
    localparam int unsigned N      = 3;
    localparam int unsigned EW     = 19;
    localparam int unsigned DW     = 25;
    localparam int unsigned DIGITS = 6;
    localparam int unsigned TICKS  = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [N*N*EW-1:0] m;

    always #5 clk = ~clk;

    matrix_hex_scroller_if #(.N(N), .EW(EW), .DW(DW), .DIGITS(DIGITS)) bus ();

    matrix_hex_scroller #(
        .N(N), .EW(EW), .DW(DW), .DIGITS(DIGITS), .TICKS(TICKS)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic logic [41:0] disp(input logic [23:0] v);
        logic [41:0] r;
`ifdef SIGNED_DISP_EN
        logic [23:0] mag;
        mag = v[23] ? (~v + 24'd1) : v;
        for (int k = 0; k < 5; k++) r[7*k +: 7] = seg(mag[4*k +: 4]);
        r[41:35] = v[23] ? 7'b0111111 : 7'b1111111;
`else
        for (int k = 0; k < 6; k++) r[7*k +: 7] = seg(v[4*k +: 4]);
`endif
        return r;
    endfunction

    function automatic logic [N*N*EW-1:0] mk_seq(input int base);
        logic [N*N*EW-1:0] r;
        for (int k = 0; k < N * N; k++) r[(N*N-1-k)*EW +: EW] = EW'(base + k);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.next = 1'b0; bus.clear = 1'b0;
        bus.auto_en = 1'b0; bus.sel_det = 1'b0;
        bus.matriz = '0; bus.det = '0;

        // Reset and idle
        tick(3);
        chk("rst_hex", 64'(bus.hex_seg), {22'd0, {42{1'b1}}});
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_idx", 64'(bus.elem_idx), 64'd0);
        rst = 1'b0;
        tick(5);
        chk("idle_hex", 64'(bus.hex_seg), {22'd0, {42{1'b1}}});
        chk("idle_valid", 64'(bus.valid), 64'd0);

        // Load 1..9 and step through with next pulses
        bus.matriz = mk_seq(1);
        bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
        chk("load_idx", 64'(bus.elem_idx), 64'd0);
        chk("load_valid_lag", 64'(bus.valid), 64'd0);
        tick(1);
        chk("load_hex", 64'(bus.hex_seg), 64'(disp(24'd1)));
        chk("load_valid", 64'(bus.valid), 64'd1);
        for (int p = 1; p <= 9; p++) begin
            bus.next = 1'b1;
            tick(1);
            bus.next = 1'b0;
            chk("next_idx", 64'(bus.elem_idx), 64'(p % 9));
            tick(1);
            chk("next_hex", 64'(bus.hex_seg), 64'(disp(24'((p % 9) + 1))));
        end

        // Timer advance every 4 cycles, coincident next, freeze
        bus.auto_en = 1'b1;
        tick(3);
        chk("auto_pre", 64'(bus.elem_idx), 64'd0);
        tick(1);
        chk("auto_1", 64'(bus.elem_idx), 64'd1);
        tick(4);
        chk("auto_2", 64'(bus.elem_idx), 64'd2);
        tick(3);
        bus.next = 1'b1;
        tick(1);
        bus.next = 1'b0;
        chk("auto_coincide", 64'(bus.elem_idx), 64'd3);
        tick(1);
        chk("auto_hex", 64'(bus.hex_seg), 64'(disp(24'd4)));
        bus.auto_en = 1'b0;
        tick(10);
        chk("auto_frozen", 64'(bus.elem_idx), 64'd3);

        // Load beats a coincident next; snapshot isolated from later matriz changes
        bus.next = 1'b1;
        tick(2);
        bus.next = 1'b0;
        chk("pre_reload_idx", 64'(bus.elem_idx), 64'd5);
        m = '0;
        m[8*EW +: EW] = 19'h7FFFE;
        m[7*EW +: EW] = 19'h0ABCD;
        bus.matriz = m;
        bus.load = 1'b1;
        bus.next = 1'b1;
        tick(1);
        bus.load = 1'b0;
        bus.next = 1'b0;
        chk("load_next_idx", 64'(bus.elem_idx), 64'd0);
        tick(1);
        chk("sext_hex", 64'(bus.hex_seg), 64'(disp(24'hFFFFFE)));
        bus.matriz = '0;
        tick(3);
        chk("isolated_hex", 64'(bus.hex_seg), 64'(disp(24'hFFFFFE)));
        bus.next = 1'b1;
        tick(1);
        bus.next = 1'b0;
        chk("iso_idx", 64'(bus.elem_idx), 64'd1);
        tick(1);
        chk("iso_hex1", 64'(bus.hex_seg), 64'(disp(24'h00ABCD)));

        // Clear in SCROLL
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        tick(1);
        chk("clear_hex", 64'(bus.hex_seg), {22'd0, {42{1'b1}}});
        chk("clear_valid", 64'(bus.valid), 64'd0);

        // Reset mid-scroll at index 7
        bus.matriz = mk_seq(1);
        bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
        bus.next = 1'b1;
        tick(7);
        bus.next = 1'b0;
        chk("pre_rst_idx", 64'(bus.elem_idx), 64'd7);
        tick(1);
        chk("pre_rst_hex", 64'(bus.hex_seg), 64'(disp(24'd8)));
        rst = 1'b1;
        tick(1);
        chk("midrst_idx", 64'(bus.elem_idx), 64'd0);
        chk("midrst_hex", 64'(bus.hex_seg), {22'd0, {42{1'b1}}});
        chk("midrst_valid", 64'(bus.valid), 64'd0);
        rst = 1'b0;
        tick(1);

        // Determinant display, next and timer ignored
        bus.det = 25'h1FFFFFD;
        bus.sel_det = 1'b1;
        bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
        bus.sel_det = 1'b0;
        tick(1);
        chk("det_hex", 64'(bus.hex_seg), 64'(disp(24'hFFFFFD)));
        chk("det_valid", 64'(bus.valid), 64'd1);
        bus.next = 1'b1;
        bus.auto_en = 1'b1;
        tick(6);
        bus.next = 1'b0;
        bus.auto_en = 1'b0;
        chk("det_hold_hex", 64'(bus.hex_seg), 64'(disp(24'hFFFFFD)));
        chk("det_hold_idx", 64'(bus.elem_idx), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
